clk_enable_gen: RTL and testbench
=================================

Name: clk_enable_gen

Overview:
- Parametrised, runtime-programmable successor to the fixed three-output PLL wrapper.
- Generates NUM_CH phase-aligned clock-enable pulses and square-wave strobes from one system clock.
- Each channel has its own divide ratio and phase offset, writable over a ready/valid config port.
- Drives the lock-in / coherent-average sample and reference timing, and reports a lock flag after every realignment.

Parameters:
- NUM_CH, 3, number of output channels (1..16).
- DIV_W, 16, width of divide-ratio and phase registers.
- DEFAULT_DIV, 4, divide ratio loaded into every channel on reset.
- LOCK_CYCLES, 16, clocks of stable running after realignment before locked asserts (>=1).
- CH_W, max(1, clog2(NUM_CH)), width of the channel index.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted.
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  DIV_W  new divide ratio.
- cfg_phase  in  DIV_W  new phase offset (counter preload).
- cfg_err  out  1  one-cycle pulse: a config with an invalid channel was accepted.
- ce_out  out  NUM_CH  per-channel enable, high one cycle per period.
- clk_out  out  NUM_CH  per-channel square-wave strobe.
- locked  out  1  all channels aligned and stable.

Behaviour:
- Reset (reset_n=0, async):
  - cnt[i]=0, div[i]=DEFAULT_DIV, phase[i]=0.
  - state=LOCKING, lock_cnt=0, locked=0, cfg_err=0.
  - ce_out and clk_out are 0 while reset is held.
  - cfg_ready=0 while reset is held.
- Effective divide ratio: d = max(div[i],1).
- Counter, every edge: cnt[i] <= (cnt[i]>=d-1) ? 0 : cnt[i]+1.
- ce_out[i] = (cnt[i]==d-1), decoded from the registered counter.
- clk_out[i] = (cnt[i] < d>>1).
  - Odd d: high for floor(d/2) of d cycles.
  - d=1: clk_out=0 and ce_out=1 constantly.
- States: LOCKING, LOCKED, ALIGN.
  - LOCKING: lock_cnt increments each edge. When lock_cnt==LOCK_CYCLES-1, next state is LOCKED. locked is high exactly LOCK_CYCLES edges after entering LOCKING.
  - LOCKED: locked=1. Holds until a valid config is accepted.
  - ALIGN: lasts one cycle, cfg_ready=0. On the exiting edge, every cnt[i] loads phase[i], or 0 if phase[i] >= d. State then goes to LOCKING with lock_cnt=0.
- cfg_ready = reset_n deasserted && state!=ALIGN. Accepts are allowed in both LOCKING and LOCKED.
- Accept (cfg_valid && cfg_ready at edge E), cfg_ch < NUM_CH:
  - div[cfg_ch] and phase[cfg_ch] are written at E.
  - State goes to ALIGN and locked=0 after E.
  - Counters keep running on the old settings until they are preloaded at E+1.
  - Every channel is realigned, not only the target.
- Accept with cfg_ch >= NUM_CH:
  - No register changes, state unchanged, locked unaffected.
  - cfg_err=1 for the cycle after E.
- An accept during LOCKING restarts the lock count through ALIGN.
- Reset mid-operation:
  - Immediately clears all outputs and shadow registers to their reset values.
  - The first edge after release behaves as the start of LOCKING.
- No combinational path from cfg_* inputs to any output except through cfg_ready.

Test Plan:
1. Reset default run (NUM_CH=3, DEFAULT_DIV=4, LOCK_CYCLES=8): release reset → each ce_out high on edges 3,7,11…; clk_out high while cnt in {0,1}; locked rises 8 edges after release.
2. Phase offset: write ch1 div=10 phase=0, then ch2 div=10 phase=5, with no gap → after each accept: cfg_ready low 1 cycle, locked 0, re-asserted 8 edges after the second ALIGN; ce_out[2] leads ce_out[1] by 5 cycles; clk_out[2] == ~clk_out[1].
3. Degenerate ratios: div=0 and div=1 → ce_out constantly 1, clk_out constantly 0; div=5 → clk_out high 2 of 5 cycles.
4. Phase >= div: ch0 div=10 phase=12 → behaves identically to phase=0, matching ch1 (div=10, phase=0) pulse-for-pulse.
5. Invalid channel and restart: cfg_ch=3 while LOCKED → cfg_err single pulse, locked stays 1, outputs unchanged. A valid write 4 cycles into LOCKING → lock count restarts; locked is delayed accordingly.
6. Async reset mid-run (between clock edges while LOCKED with custom divs) → ce_out, clk_out, locked and cfg_ready go 0 without waiting for an edge; after release, all channels return to DEFAULT_DIV behaviour of test 1.

Source files
------------

// File: rtl/clk_enable_gen.sv
// Runtime-programmable multi-channel clock-enable and square-wave strobe generator.
// Any accepted config realigns every channel, then locked re-asserts after a stable interval.
module clk_enable_gen #(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4,
    parameter int LOCK_CYCLES = 16,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        LOCKING = 2'd0,
        LOCKED  = 2'd1,
        ALIGN   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [LC_W-1:0] lock_cnt;
    logic            accept;
    logic            ch_valid;
    logic            accept_ok;

    assign ch_valid  = 32'(cfg_ch) < NUM_CH;
    assign accept    = cfg_valid && (state != ALIGN);
    assign accept_ok = accept && ch_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LOCKING;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOCKING: begin
                if (accept_ok) begin
                    state_next = ALIGN;
                end else if (lock_cnt == LC_W'(LOCK_CYCLES - 1)) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (accept_ok) begin
                    state_next = ALIGN;
                end
            end
            ALIGN:   state_next = LOCKING;
            default: state_next = LOCKING;
        endcase
    end

    always_comb begin
        cfg_ready = reset_n && (state != ALIGN);
        locked    = (state == LOCKED);
    end

    // Lock counter only advances while staying in LOCKING; any other path restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt <= '0;
        end else if ((state == LOCKING) && (state_next == LOCKING)) begin
            lock_cnt <= lock_cnt + LC_W'(1);
        end else begin
            lock_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && !ch_valid;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] phase_q;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] d_eff;
        logic             sel;

        assign sel   = accept_ok && (cfg_ch == CH_W'(i));
        assign d_eff = (div_q == '0) ? DIV_W'(1) : div_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                div_q   <= DIV_W'(DEFAULT_DIV);
                phase_q <= '0;
            end else if (sel) begin
                div_q   <= cfg_div;
                phase_q <= cfg_phase;
            end
        end

        // ALIGN sees the freshly written div/phase; an out-of-range phase falls back to 0.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else if (state == ALIGN) begin
                cnt_q <= (phase_q >= d_eff) ? '0 : phase_q;
            end else if (cnt_q >= d_eff - DIV_W'(1)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end

        assign ce_out[i]  = reset_n && (cnt_q == d_eff - DIV_W'(1));
        assign clk_out[i] = reset_n && (cnt_q < (d_eff >> 1));
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed-plus-random bench for clk_enable_gen against a modulo-arithmetic channel/lock model.
module tb_clk_enable_gen;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 4;
    localparam int LOCK_CYCLES = 8;
    localparam int CH_W        = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic [DIV_W-1:0]  cfg_phase = '0;
    logic              cfg_err;
    logic [NUM_CH-1:0] ce_out;
    logic [NUM_CH-1:0] clk_out;
    logic              locked;

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel count position, lock measured as edges since realignment.
    int m_div[NUM_CH];
    int m_ph[NUM_CH];
    int m_cnt[NUM_CH];
    bit m_align;
    int m_since;
    bit m_err;

    always #5 clk = ~clk;

    clk_enable_gen #(
        .NUM_CH(NUM_CH),
        .DIV_W(DIV_W),
        .DEFAULT_DIV(DEFAULT_DIV),
        .LOCK_CYCLES(LOCK_CYCLES),
        .CH_W(CH_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_phase(cfg_phase),
        .cfg_err(cfg_err),
        .ce_out(ce_out),
        .clk_out(clk_out),
        .locked(locked)
    );

    function automatic int eff(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = DEFAULT_DIV;
            m_ph[i]  = 0;
            m_cnt[i] = 0;
        end
        m_align = 0;
        m_since = 0;
        m_err   = 0;
    endtask

    task automatic model_edge();
        bit acc;
        bit ok;
        if (!reset_n) begin
            model_reset();
            return;
        end
        acc = cfg_valid && !m_align;
        ok  = acc && (int'(cfg_ch) < NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_align) m_cnt[i] = (m_ph[i] < eff(m_div[i])) ? m_ph[i] : 0;
            else         m_cnt[i] = (m_cnt[i] + 1) % eff(m_div[i]);
        end
        if (m_align) begin
            m_align = 0;
            m_since = 0;
        end else if (ok) begin
            m_align = 1;
        end else if (m_since < LOCK_CYCLES) begin
            m_since++;
        end
        if (ok) begin
            m_div[cfg_ch] = int'(cfg_div);
            m_ph[cfg_ch]  = int'(cfg_phase);
        end
        m_err = acc && !ok;
    endtask

    task automatic check_all(input string tag);
        logic [NUM_CH-1:0] e_ce;
        logic [NUM_CH-1:0] e_clk;
        logic e_rdy;
        logic e_lk;
        logic e_err;
        for (int i = 0; i < NUM_CH; i++) begin
            e_ce[i]  = reset_n && (m_cnt[i] == eff(m_div[i]) - 1);
            e_clk[i] = reset_n && (m_cnt[i] < eff(m_div[i]) / 2);
        end
        e_rdy = reset_n && !m_align;
        e_lk  = reset_n && !m_align && (m_since >= LOCK_CYCLES);
        e_err = m_err;
        checks += 5;
        assert (ce_out === e_ce) else begin
            errors++; $error("FAIL %s ce_out got=%b exp=%b", tag, ce_out, e_ce);
        end
        assert (clk_out === e_clk) else begin
            errors++; $error("FAIL %s clk_out got=%b exp=%b", tag, clk_out, e_clk);
        end
        assert (cfg_ready === e_rdy) else begin
            errors++; $error("FAIL %s cfg_ready got=%b exp=%b", tag, cfg_ready, e_rdy);
        end
        assert (locked === e_lk) else begin
            errors++; $error("FAIL %s locked got=%b exp=%b", tag, locked, e_lk);
        end
        assert (cfg_err === e_err) else begin
            errors++; $error("FAIL %s cfg_err got=%b exp=%b", tag, cfg_err, e_err);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic cfg_write(input int ch, input int dv, input int ph, input string tag);
        bit done;
        done      = 0;
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(dv);
        cfg_phase = DIV_W'(ph);
        for (int k = 0; k < 4 && !done; k++) begin
            done = !m_align;
            cycle(tag);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic default_run(input string tag);
        for (int e = 1; e <= 12; e++) begin
            cycle(tag);
            checks += 2;
            assert (ce_out === ((e % 4 == 3) ? 3'b111 : 3'b000)) else begin
                errors++; $error("FAIL %s_ce edge%0d got=%b", tag, e, ce_out);
            end
            assert (locked === (e >= LOCK_CYCLES)) else begin
                errors++; $error("FAIL %s_locked edge%0d got=%b exp=%b", tag, e, locked, e >= LOCK_CYCLES);
            end
        end
    endtask

    initial begin
        int f1;
        int f2;
        int hi;

        // Test 1: reset state then default divide-by-4 run
        model_reset();
        repeat (3) cycle("reset_hold");
        checks++;
        assert (ce_out === 3'b000 && clk_out === 3'b000 && locked === 1'b0 && cfg_ready === 1'b0 && cfg_err === 1'b0) else begin
            errors++; $error("FAIL reset_state ce=%b clk=%b lk=%b rdy=%b err=%b exp all 0", ce_out, clk_out, locked, cfg_ready, cfg_err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        default_run("default");

        // Test 2: back-to-back writes, ch2 phase 5 against ch1 phase 0
        cfg_write(1, 10, 0, "phase_wr1");
        checks++;
        assert (cfg_ready === 1'b0 && locked === 1'b0) else begin
            errors++; $error("FAIL align_after_wr1 rdy=%b lk=%b exp 0 0", cfg_ready, locked);
        end
        cfg_write(2, 10, 5, "phase_wr2");
        cycle("phase_align");
        f1 = -1;
        f2 = -1;
        for (int t = 1; t <= 12; t++) begin
            cycle("phase_run");
            if (ce_out[1] && f1 < 0) f1 = t;
            if (ce_out[2] && f2 < 0) f2 = t;
            checks += 2;
            assert (clk_out[2] === ~clk_out[1]) else begin
                errors++; $error("FAIL phase_clk t%0d clk_out=%b exp bit2=~bit1", t, clk_out);
            end
            assert (locked === (t >= LOCK_CYCLES)) else begin
                errors++; $error("FAIL phase_relock t%0d got=%b", t, locked);
            end
        end
        checks++;
        assert (f2 == 4 && f1 - f2 == 5) else begin
            errors++; $error("FAIL phase_lead first_ce1=%0d first_ce2=%0d exp 9 4", f1, f2);
        end

        // Test 3: degenerate ratios 0 and 1, odd ratio 5
        cfg_write(0, 0, 0, "degen_wr0");
        cfg_write(1, 1, 0, "degen_wr1");
        cfg_write(2, 5, 0, "degen_wr2");
        cycle("degen_align");
        hi = 0;
        for (int t = 0; t < 10; t++) begin
            cycle("degen_run");
            if (clk_out[2]) hi++;
            checks++;
            assert (ce_out[1:0] === 2'b11 && clk_out[1:0] === 2'b00) else begin
                errors++; $error("FAIL degen_const ce=%b clk=%b exp ce[1:0]=11 clk[1:0]=00", ce_out, clk_out);
            end
        end
        checks++;
        assert (hi == 4) else begin
            errors++; $error("FAIL odd_duty high=%0d exp 4", hi);
        end

        // Test 4: phase beyond ratio behaves as phase 0
        cfg_write(0, 10, 12, "phge_wr0");
        cfg_write(1, 10, 0, "phge_wr1");
        cycle("phge_align");
        for (int t = 0; t < 25; t++) begin
            cycle("phge_run");
            checks++;
            assert (ce_out[0] === ce_out[1] && clk_out[0] === clk_out[1]) else begin
                errors++; $error("FAIL phge_match t%0d ce=%b clk=%b", t, ce_out, clk_out);
            end
        end

        // Test 5: invalid channel, then restart of the lock count
        repeat (10) cycle("pre_inval");
        checks++;
        assert (locked === 1'b1) else begin
            errors++; $error("FAIL pre_inval_locked got=%b exp 1", locked);
        end
        cfg_write(3, 7, 7, "inval_wr");
        checks++;
        assert (cfg_err === 1'b1 && locked === 1'b1) else begin
            errors++; $error("FAIL inval_pulse err=%b lk=%b exp 1 1", cfg_err, locked);
        end
        cycle("inval_after");
        checks++;
        assert (cfg_err === 1'b0) else begin
            errors++; $error("FAIL inval_single got=%b exp 0", cfg_err);
        end
        cfg_write(0, 6, 0, "restart_wr0");
        cycle("restart_align0");
        repeat (4) cycle("restart_locking");
        cfg_write(1, 6, 3, "restart_wr1");
        cycle("restart_align1");
        for (int t = 1; t <= LOCK_CYCLES; t++) begin
            cycle("restart_run");
            checks++;
            assert (locked === (t == LOCK_CYCLES)) else begin
                errors++; $error("FAIL restart_locked t%0d got=%b", t, locked);
            end
        end

        // Test 6: asynchronous reset between edges
        repeat (3) cycle("pre_areset");
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        assert (ce_out === 3'b000 && clk_out === 3'b000 && locked === 1'b0 && cfg_ready === 1'b0) else begin
            errors++; $error("FAIL areset_immediate ce=%b clk=%b lk=%b rdy=%b exp all 0", ce_out, clk_out, locked, cfg_ready);
        end
        repeat (2) cycle("areset_hold");
        @(negedge clk);
        reset_n = 1'b1;
        default_run("post_areset");

        // Randomized configuration traffic
        for (int n = 0; n < 400; n++) begin
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 3));
            cfg_div   = DIV_W'($urandom_range(0, 12));
            cfg_phase = DIV_W'($urandom_range(0, 15));
            cycle("random");
        end
        cfg_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
